// File: rtl/shape_pkg.sv
// Shared types for the shape-record table (reader and writer).
package shape_pkg;

    localparam int unsigned FIELDS       = 5;
    localparam int unsigned FIELDW       = 3;
    localparam int unsigned SHAPE_CORDW  = 10;
    localparam int unsigned SHAPE_DATAW  = 12;

    typedef enum logic [FIELDW-1:0] {
        FIELD_TY     = 3'd0,
        FIELD_X      = 3'd1,
        FIELD_Y      = 3'd2,
        FIELD_SIZE   = 3'd3,
        FIELD_ROTATE = 3'd4
    } field_e;

    typedef struct packed {
        logic [SHAPE_DATAW-1:0] ty;
        logic [SHAPE_CORDW-1:0] x;
        logic [SHAPE_CORDW-1:0] y;
        logic [SHAPE_DATAW-1:0] size;
        logic [SHAPE_DATAW-1:0] rotate;
    } shape_t;

endpackage

// File: rtl/shape_tag_pipe.sv
// Delay line carrying {valid, field} alongside each RAM read.
module shape_tag_pipe #(
    parameter int unsigned LAT = 1,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_tag,
    output logic [W-1:0] o_tag
);

    logic [LAT*W-1:0] r_sr;

    generate
        if (LAT == 1) begin : g_one
            // Single stage: register the tag.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= i_tag;
            end
        end else begin : g_many
            // Multi-stage shift, newest tag in the low slot.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_sr <= '0;
                else        r_sr <= {r_sr[(LAT-1)*W-1:0], i_tag};
            end
        end
    endgenerate

    assign o_tag = r_sr[LAT*W-1 -: W];

endmodule

// File: rtl/shape_fetch.sv
// Sequential reader of the shape-record table; one shape per handshake.
module shape_fetch
    import shape_pkg::*;
#(
    parameter int unsigned DATAB  = 3,
    parameter int unsigned CORDW  = 10,
    parameter int unsigned ADDRW  = 20,
    parameter int unsigned DATAW  = 12,
    parameter int unsigned NUMW   = DATAW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUMW-1:0]  count,
    input  logic [ADDRW-1:0] ram_address_offset,
    output logic [ADDRW-1:0] ram_address,
    output logic             ram_enable,
    input  logic [DATAW-1:0] ram_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUMW-1:0]  out_id,
    output logic [DATAW-1:0] out_ty,
    output logic [CORDW-1:0] out_x,
    output logic [CORDW-1:0] out_y,
    output logic [DATAW-1:0] out_size,
    output logic [DATAW-1:0] out_rotate,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TAGW = FIELDW + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_DRAIN, ST_PRESENT, ST_DONE
    } state_e;

    state_e             r_state, w_state_n;
    logic [FIELDW-1:0]  r_ptr, w_ptr_n;
    logic [NUMW-1:0]    r_id, w_id_n, w_id_inc;
    logic [NUMW-1:0]    r_count, w_count_n;
    logic [ADDRW-1:0]   r_offset, w_offset_n;
    logic [ADDRW-1:0]   r_ram_address, w_ram_address_n;
    logic               r_ram_enable, w_ram_enable_n;
    logic               r_out_valid, w_out_valid_n;
    logic [NUMW-1:0]    r_out_id, w_out_id_n;
    logic [DATAW-1:0]   r_ty, w_ty_n;
    logic [CORDW-1:0]   r_x, w_x_n;
    logic [CORDW-1:0]   r_y, w_y_n;
    logic [DATAW-1:0]   r_size, w_size_n;
    logic [DATAW-1:0]   r_rotate, w_rotate_n;
    logic               r_busy, w_busy_n;
    logic               r_done, w_done_n;
    logic [TAGW-1:0]    w_tag;
    logic               w_tag_valid;
    logic [FIELDW-1:0]  w_tag_ptr;

    function automatic logic [ADDRW-1:0] rec_addr(input logic [NUMW-1:0]   id,
                                                  input logic [ADDRW-1:0]  base,
                                                  input logic [FIELDW-1:0] ptr);
        return (ADDRW'(id) << DATAB) + base + ADDRW'(ptr);
    endfunction

    shape_tag_pipe #(
        .LAT (RD_LAT),
        .W   (TAGW)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag ({r_ram_enable, r_ptr}),
        .o_tag (w_tag)
    );

    assign w_tag_valid = w_tag[TAGW-1];
    assign w_tag_ptr   = w_tag[FIELDW-1:0];
    assign w_id_inc    = r_id + NUMW'(1);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_id          <= '0;
            r_count       <= '0;
            r_offset      <= '0;
            r_ram_address <= '0;
            r_ram_enable  <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_id      <= '0;
            r_ty          <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_size        <= '0;
            r_rotate      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_ptr         <= w_ptr_n;
            r_id          <= w_id_n;
            r_count       <= w_count_n;
            r_offset      <= w_offset_n;
            r_ram_address <= w_ram_address_n;
            r_ram_enable  <= w_ram_enable_n;
            r_out_valid   <= w_out_valid_n;
            r_out_id      <= w_out_id_n;
            r_ty          <= w_ty_n;
            r_x           <= w_x_n;
            r_y           <= w_y_n;
            r_size        <= w_size_n;
            r_rotate      <= w_rotate_n;
            r_busy        <= w_busy_n;
            r_done        <= w_done_n;
        end
    end

    // Next-state, read issue, field capture and handshake.
    always_comb begin
        w_state_n       = r_state;
        w_ptr_n         = r_ptr;
        w_id_n          = r_id;
        w_count_n       = r_count;
        w_offset_n      = r_offset;
        w_ram_address_n = r_ram_address;
        w_ram_enable_n  = 1'b0;
        w_out_valid_n   = r_out_valid;
        w_out_id_n      = r_out_id;
        w_ty_n          = r_ty;
        w_x_n           = r_x;
        w_y_n           = r_y;
        w_size_n        = r_size;
        w_rotate_n      = r_rotate;
        w_done_n        = 1'b0;

        if (w_tag_valid) begin
            case (field_e'(w_tag_ptr))
                FIELD_TY:     w_ty_n     = ram_data;
                FIELD_X:      w_x_n      = ram_data[CORDW-1:0];
                FIELD_Y:      w_y_n      = ram_data[CORDW-1:0];
                FIELD_SIZE:   w_size_n   = ram_data;
                FIELD_ROTATE: w_rotate_n = ram_data;
                default:      ;
            endcase
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_count_n  = count;
                    w_offset_n = ram_address_offset;
                    w_id_n     = '0;
                    if (count == '0) begin
                        w_state_n = ST_DONE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n       = ST_ISSUE;
                        w_ptr_n         = '0;
                        w_ram_address_n = rec_addr('0, ram_address_offset, '0);
                        w_ram_enable_n  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (r_ptr == FIELD_ROTATE) begin
                    w_state_n = ST_DRAIN;
                end else begin
                    w_ptr_n         = r_ptr + FIELDW'(1);
                    w_ram_address_n = rec_addr(r_id, r_offset, r_ptr + FIELDW'(1));
                    w_ram_enable_n  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_tag_valid && (w_tag_ptr == FIELD_ROTATE)) begin
                    w_state_n     = ST_PRESENT;
                    w_out_valid_n = 1'b1;
                    w_out_id_n    = r_id;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    w_out_valid_n = 1'b0;
                    w_id_n        = w_id_inc;
                    if (w_id_inc == r_count) begin
                        w_state_n = ST_DONE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n       = ST_ISSUE;
                        w_ptr_n         = '0;
                        w_ram_address_n = rec_addr(w_id_inc, r_offset, '0);
                        w_ram_enable_n  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        w_busy_n = (w_state_n != ST_IDLE);
    end

    assign ram_address = r_ram_address;
    assign ram_enable  = r_ram_enable;
    assign out_valid   = r_out_valid;
    assign out_id      = r_out_id;
    assign out_ty      = r_ty;
    assign out_x       = r_x;
    assign out_y       = r_y;
    assign out_size    = r_size;
    assign out_rotate  = r_rotate;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_shape_fetch.sv
// Directed bench for shape_fetch at RD_LAT=1 (u_dut) and RD_LAT=2 (u_dut2).
module tb_shape_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic [11:0] count, count2;
    logic [19:0] offset, offset2;
    logic        out_ready, out_ready2;

    logic [19:0] ram_address, ram_address2;
    logic        ram_enable, ram_enable2;
    logic [11:0] ram_data, ram_data2;
    logic        out_valid, out_valid2;
    logic [11:0] out_id, out_id2, out_ty, out_ty2, out_size, out_size2, out_rotate, out_rotate2;
    logic [9:0]  out_x, out_x2, out_y, out_y2;
    logic        busy, busy2, done, done2;

    logic [11:0] mem [4096];
    logic [11:0] rd1, rd2a, rd2b;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    int vrise_cnt = 0;
    logic prev_v = 1'b0;
    logic [19:0] addr_q [$];

    always #5 clk = ~clk;

    shape_fetch #(.RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count),
        .ram_address_offset(offset), .ram_address(ram_address), .ram_enable(ram_enable),
        .ram_data(ram_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_ty(out_ty), .out_x(out_x), .out_y(out_y),
        .out_size(out_size), .out_rotate(out_rotate), .busy(busy), .done(done)
    );

    shape_fetch #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .count(count2),
        .ram_address_offset(offset2), .ram_address(ram_address2), .ram_enable(ram_enable2),
        .ram_data(ram_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_id(out_id2), .out_ty(out_ty2), .out_x(out_x2), .out_y(out_y2),
        .out_size(out_size2), .out_rotate(out_rotate2), .busy(busy2), .done(done2)
    );

    // RAM models: one- and two-cycle read latency.
    always @(posedge clk) begin
        if (ram_enable) rd1 <= mem[ram_address[11:0]];
        if (ram_enable2) rd2a <= mem[ram_address2[11:0]];
        rd2b <= rd2a;
    end
    assign ram_data  = rd1;
    assign ram_data2 = rd2b;

    // Read and valid-edge monitor for u_dut.
    always @(posedge clk) begin
        prev_v <= out_valid;
        if (out_valid && !prev_v) vrise_cnt <= vrise_cnt + 1;
        if (ram_enable) begin
            en_cnt <= en_cnt + 1;
            addr_q.push_back(ram_address);
        end
    end

    function automatic logic [11:0] pat(input logic [19:0] a);
        return a[11:0] ^ 12'hA5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    endtask

    task automatic wait_valid2(output int k);
        k = 0;
        while (out_valid2 !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    endtask

    task automatic chk_rec(input string tag, input logic [11:0] id, input logic [19:0] base);
        chk({tag, ".id"},  32'(out_id), 32'(id));
        chk({tag, ".ty"},  32'(out_ty), 32'(pat(base)));
        chk({tag, ".x"},   32'(out_x), 32'(pat(base + 20'd1) & 12'h3FF));
        chk({tag, ".y"},   32'(out_y), 32'(pat(base + 20'd2) & 12'h3FF));
        chk({tag, ".size"}, 32'(out_size), 32'(pat(base + 20'd3)));
        chk({tag, ".rot"}, 32'(out_rotate), 32'(pat(base + 20'd4)));
    endtask

    task automatic chk_rec2(input string tag, input logic [11:0] id, input logic [19:0] base);
        chk({tag, ".id"},  32'(out_id2), 32'(id));
        chk({tag, ".ty"},  32'(out_ty2), 32'(pat(base)));
        chk({tag, ".x"},   32'(out_x2), 32'(pat(base + 20'd1) & 12'h3FF));
        chk({tag, ".y"},   32'(out_y2), 32'(pat(base + 20'd2) & 12'h3FF));
        chk({tag, ".size"}, 32'(out_size2), 32'(pat(base + 20'd3)));
        chk({tag, ".rot"}, 32'(out_rotate2), 32'(pat(base + 20'd4)));
    endtask

    initial begin
        int k, e0, v0, q0;
        logic stable;
        logic [11:0] s_ty, s_size, s_rot, s_id;
        logic [9:0]  s_x, s_y;

        for (int i = 0; i < 4096; i++) mem[i] = 12'(i) ^ 12'hA5A;
        mem[12'h110] = 12'd5;
        mem[12'h111] = 12'h123;
        mem[12'h112] = 12'h045;
        mem[12'h113] = 12'd40;
        mem[12'h114] = 12'd90;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        count = '0; count2 = '0; offset = '0; offset2 = '0;
        out_ready = 1'b0; out_ready2 = 1'b0;
        tick(2);

        // reset state
        chk("rst.addr", 32'(ram_address), 32'h0);
        chk("rst.en", 32'(ram_enable), 32'h0);
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.ty", 32'(out_ty), 32'h0);
        chk("rst.busy2", 32'(busy2), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // count == 0
        e0 = en_cnt; v0 = vrise_cnt;
        count = 12'd0; start = 1'b1;
        tick(1);
        chk("c0.done", 32'(done), 32'h1);
        chk("c0.busy", 32'(busy), 32'h1);
        start = 1'b0;
        tick(1);
        chk("c0.done_fall", 32'(done), 32'h0);
        chk("c0.busy_fall", 32'(busy), 32'h0);
        tick(2);
        chk("c0.no_reads", 32'(en_cnt - e0), 32'h0);
        chk("c0.no_valid", 32'(vrise_cnt - v0), 32'h0);

        // count=3, offset 0x100, ready high, mid-scan start ignored
        q0 = addr_q.size(); e0 = en_cnt;
        count = 12'd3; offset = 20'h100; out_ready = 1'b1; start = 1'b1;
        tick(1);
        chk("s3.addr_f0", 32'(ram_address), 32'h100);
        chk("s3.en_f0", 32'(ram_enable), 32'h1);
        start = 1'b0;
        tick(4);
        chk("s3.addr_f4", 32'(ram_address), 32'h104);
        tick(1);
        chk("s3.en_fall", 32'(ram_enable), 32'h0);
        wait_valid(k);
        chk("s3.first_valid_edge", 32'(5 + k), 32'd6);
        chk_rec("s3.id0", 12'd0, 20'h100);
        tick(1);
        chk("s3.valid_fall", 32'(out_valid), 32'h0);
        chk("s3.id1_issue_addr", 32'(ram_address), 32'h108);
        chk("s3.id1_issue_en", 32'(ram_enable), 32'h1);
        start = 1'b1; count = 12'd9; offset = 20'h300;
        tick(1);
        start = 1'b0;
        wait_valid(k);
        chk("s3.id1_valid_edge", 32'(k + 1), 32'd6);
        chk_rec("s3.id1", 12'd1, 20'h108);
        tick(1);
        wait_valid(k);
        chk("s3.id2_valid_edge", 32'(k), 32'd6);
        chk("s3.id2.id", 32'(out_id), 32'd2);
        chk("s3.id2.ty", 32'(out_ty), 32'd5);
        chk("s3.id2.x", 32'(out_x), 32'h123);
        chk("s3.id2.y", 32'(out_y), 32'h045);
        chk("s3.id2.size", 32'(out_size), 32'd40);
        chk("s3.id2.rot", 32'(out_rotate), 32'd90);
        tick(1);
        chk("s3.done", 32'(done), 32'h1);
        chk("s3.valid_low", 32'(out_valid), 32'h0);
        tick(1);
        chk("s3.done_fall", 32'(done), 32'h0);
        chk("s3.busy_fall", 32'(busy), 32'h0);
        chk("s3.reads", 32'(en_cnt - e0), 32'd15);
        chk("s3.q_size", 32'(addr_q.size() - q0), 32'd15);
        chk("s3.rec2_first", 32'(addr_q[q0 + 10]), 32'h110);
        chk("s3.rec2_last", 32'(addr_q[q0 + 14]), 32'h114);

        // backpressure on id 0
        count = 12'd2; offset = 20'h100; out_ready = 1'b0; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_valid(k);
        chk("bp.valid_edge", 32'(k), 32'd6);
        s_id = out_id; s_ty = out_ty; s_x = out_x; s_y = out_y; s_size = out_size; s_rot = out_rotate;
        e0 = en_cnt; stable = 1'b1;
        repeat (10) begin
            tick(1);
            if (out_valid !== 1'b1 || out_id !== s_id || out_ty !== s_ty || out_x !== s_x ||
                out_y !== s_y || out_size !== s_size || out_rotate !== s_rot) stable = 1'b0;
        end
        chk("bp.stable", 32'(stable), 32'h1);
        chk("bp.no_reads", 32'(en_cnt - e0), 32'h0);
        chk_rec("bp.id0", 12'd0, 20'h100);
        out_ready = 1'b1;
        tick(1);
        chk("bp.valid_fall", 32'(out_valid), 32'h0);
        chk("bp.id1_en", 32'(ram_enable), 32'h1);
        chk("bp.id1_addr", 32'(ram_address), 32'h108);
        wait_valid(k);
        chk("bp.id1_valid_edge", 32'(k), 32'd6);
        chk_rec("bp.id1", 12'd1, 20'h108);
        tick(1);
        chk("bp.done", 32'(done), 32'h1);
        tick(1);

        // RD_LAT=2 instance
        count2 = 12'd2; offset2 = 20'h180; out_ready2 = 1'b1; start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        wait_valid2(k);
        chk("l2.first_valid_edge", 32'(k), 32'd7);
        chk_rec2("l2.id0", 12'd0, 20'h180);
        tick(1);
        wait_valid2(k);
        chk("l2.id1_valid_edge", 32'(k), 32'd7);
        chk_rec2("l2.id1", 12'd1, 20'h188);
        tick(1);
        chk("l2.done", 32'(done2), 32'h1);
        tick(1);
        chk("l2.busy_fall", 32'(busy2), 32'h0);

        // reset during ISSUE of id 1, then a clean count=1 scan
        count = 12'd2; offset = 20'h100; out_ready = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_valid(k);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.en", 32'(ram_enable), 32'h0);
        chk("ar.addr", 32'(ram_address), 32'h0);
        chk("ar.busy", 32'(busy), 32'h0);
        chk("ar.valid", 32'(out_valid), 32'h0);
        chk("ar.ty", 32'(out_ty), 32'h0);
        chk("ar.x", 32'(out_x), 32'h0);
        chk("ar.rot", 32'(out_rotate), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        count = 12'd1; offset = 20'h200; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_valid(k);
        chk("ar.valid_edge", 32'(k), 32'd6);
        chk_rec("ar.id0", 12'd0, 20'h200);
        tick(1);
        chk("ar.done", 32'(done), 32'h1);
        tick(1);
        chk("ar.busy_fall", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
